fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC_if value after reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000000, value loaded into Instr_id on bubble or flush.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 PC_in  input  32  next-PC selection from the PC mux.
REQ-006 Stall_if  input  1  hold request from hazard unit.
REQ-007 Flush_if  input  1  redirect (taken branch/jump/jr); squashes the IF/ID register.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  32  instruction memory address.
REQ-010 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-011 imem_ready  input  1  memory completes the current request this cycle.
REQ-012 PC_if  output  32  current fetch PC register.
REQ-013 NextPC_if  output  32  combinational PC_if+4, fed to the PC mux.
REQ-014 Instr_id  output  32  IF/ID instruction register.
REQ-015 NextPC_id  output  32  IF/ID register holding fetched PC+4.
REQ-016 Valid_id  output  1  IF/ID contents are a real instruction.

Function
REQ-017 States SHALL be FETCH, HOLD, DRAIN; reset state FETCH.
REQ-018 NextPC_if SHALL equal PC_if+32'd4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-019 imem_req SHALL be 1 in FETCH and DRAIN, 0 in HOLD; imem_addr SHALL be PC_if in FETCH/HOLD and drain_addr in DRAIN.
REQ-020 imem_addr SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-021 IF/ID priority per cycle SHALL be: Flush_if (load NOP_INSTR, Valid_id=0) > Stall_if (hold) > deliver (load word, NextPC_id=PC_if+4, Valid_id=1) > bubble (NOP_INSTR, Valid_id=0).
REQ-022 FETCH, imem_ready=1, Flush_if=0, Stall_if=0: deliver imem_rdata; PC_if<=PC_in; stay FETCH.
REQ-023 FETCH, imem_ready=1, Flush_if=0, Stall_if=1: capture imem_rdata into hold buffer; PC_if unchanged; go HOLD.
REQ-024 FETCH, imem_ready=1, Flush_if=1: discard word; PC_if<=PC_in; stay FETCH.
REQ-025 FETCH, imem_ready=0, Flush_if=0: PC_if unchanged; IF/ID per REQ-021 (bubble if not stalled).
REQ-026 FETCH, imem_ready=0, Flush_if=1: drain_addr<=PC_if; PC_if<=PC_in; go DRAIN.
REQ-027 HOLD, Flush_if=0, Stall_if=0: deliver hold buffer; PC_if<=PC_in; go FETCH.
REQ-028 HOLD, Flush_if=0, Stall_if=1: stay HOLD, all registers unchanged.
REQ-029 HOLD, Flush_if=1: discard buffer; PC_if<=PC_in; go FETCH.
REQ-030 DRAIN, imem_ready=1: discard word; go FETCH (PC_if already redirected).
REQ-031 DRAIN, Flush_if=1: PC_if<=PC_in, drain_addr unchanged; concurrent imem_ready=1 SHALL still go FETCH.
REQ-032 No word fetched from a squashed path SHALL ever reach Instr_id with Valid_id=1.
REQ-033 Throughput SHALL be one instruction per cycle with zero-wait memory; fetch-to-IF/ID latency one cycle.

Reset
REQ-034 rst=1 SHALL immediately force PC_if=RESET_PC, Instr_id=NOP_INSTR, NextPC_id=0, Valid_id=0, hold buffer=0, drain_addr=0, state FETCH, regardless of clk.
REQ-035 Reset asserted mid-request SHALL abandon the request; first post-reset imem_addr SHALL be RESET_PC.

Verification
REQ-036 Zero-wait memory, PC_in=NextPC_if, 4 cycles -> imem_addr 0,4,8,C; Valid_id=1 from cycle 2; NextPC_id 4,8,C.
REQ-037 Ready at PC=8 with Stall_if=1 for 3 cycles, rdata=0x1234 -> state HOLD, Instr_id held, imem_req=0; on release Instr_id=0x1234, NextPC_id=0xC.
REQ-038 Request at PC=0x10 pending, Flush_if=1 with PC_in=0x40 -> DRAIN, imem_addr stays 0x10; on ready word dropped, next imem_addr=0x40, Valid_id=0.
REQ-039 Flush_if and Stall_if both 1 in HOLD -> Valid_id=0, Instr_id=NOP_INSTR, PC_if=PC_in, state FETCH.
REQ-040 PC_if=0xFFFFFFFC -> NextPC_if=0x00000000; rst pulsed between clock edges mid-fetch -> outputs reset asynchronously, next address RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : IF stage: PC register, instruction memory handshake, IF/ID register
//            with a one-word hold buffer and a drain state for squashed requests.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_in,
    input  logic        Stall_if,
    input  logic        Flush_if,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] PC_if,
    output logic [31:0] NextPC_if,
    output logic [31:0] Instr_id,
    output logic [31:0] NextPC_id,
    output logic        Valid_id
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [31:0] hold_buf;
    logic [31:0] drain_addr;

    logic        pc_load;
    logic        deliver;
    logic        capture;
    logic        drain_load;
    logic [31:0] deliver_word;

    assign NextPC_if = PC_if + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (imem_ready && !Flush_if && Stall_if) begin
                    next_state = ST_HOLD;
                end else if (!imem_ready && Flush_if) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                if (Flush_if || !Stall_if) begin
                    next_state = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ready) begin
                    next_state = ST_FETCH;
                end
            end
            default: next_state = ST_FETCH;
        endcase
    end

    // The outstanding request keeps its address in DRAIN; PC_if already points at the new path.
    always_comb begin
        imem_req     = 1'b1;
        imem_addr    = PC_if;
        pc_load      = 1'b0;
        deliver      = 1'b0;
        capture      = 1'b0;
        drain_load   = 1'b0;
        deliver_word = imem_rdata;
        case (state)
            ST_FETCH: begin
                pc_load    = Flush_if || (imem_ready && !Stall_if);
                deliver    = imem_ready && !Flush_if && !Stall_if;
                capture    = imem_ready && !Flush_if && Stall_if;
                drain_load = !imem_ready && Flush_if;
            end
            ST_HOLD: begin
                imem_req     = 1'b0;
                pc_load      = Flush_if || !Stall_if;
                deliver      = !Flush_if && !Stall_if;
                deliver_word = hold_buf;
            end
            ST_DRAIN: begin
                imem_addr = drain_addr;
                pc_load   = Flush_if;
            end
            default: begin
                imem_req = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC_if      <= RESET_PC;
            Instr_id   <= NOP_INSTR;
            NextPC_id  <= 32'd0;
            Valid_id   <= 1'b0;
            hold_buf   <= 32'd0;
            drain_addr <= 32'd0;
        end else begin
            if (pc_load) begin
                PC_if <= PC_in;
            end
            if (capture) begin
                hold_buf <= imem_rdata;
            end
            if (drain_load) begin
                drain_addr <= PC_if;
            end
            if (Flush_if) begin
                Instr_id <= NOP_INSTR;
                Valid_id <= 1'b0;
            end else if (Stall_if) begin
                Instr_id <= Instr_id;
                Valid_id <= Valid_id;
            end else if (deliver) begin
                Instr_id  <= deliver_word;
                NextPC_id <= NextPC_if;
                Valid_id  <= 1'b1;
            end else begin
                Instr_id <= NOP_INSTR;
                Valid_id <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
